// File: rtl/csr_uart_rx_pkg.sv
// Shared constants, FSM state type and divisor update helper for the CSR-mapped UART receiver.
package uart_pkg;

  localparam logic [11:0] CSR_UART     = 12'hbc0;
  localparam logic [11:0] CSR_UART_DIV = 12'hbc1;

  localparam int unsigned VALID_BIT   = 8;
  localparam int unsigned OVERRUN_BIT = 9;
  localparam int unsigned FRAME_BIT   = 10;

  localparam logic [15:0] DIV_MIN = 16'd2;

  localparam logic [2:0] MOD_WRITE = 3'd1;
  localparam logic [2:0] MOD_SET   = 3'd2;
  localparam logic [2:0] MOD_CLEAR = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Applies a CSR write/set/clear to the divisor; results below DIV_MIN are clamped.
  function automatic logic [15:0] div_update(input logic [2:0] op, input logic [15:0] cur,
                                             input logic [15:0] arg);
    logic [15:0] res;
    case (op)
      MOD_WRITE: res = arg;
      MOD_SET:   res = cur | arg;
      MOD_CLEAR: res = cur & ~arg;
      default:   res = cur;
    endcase
    return (res < DIV_MIN) ? DIV_MIN : res;
  endfunction

endpackage

// File: rtl/csr_uart_rx_if.sv
// CSR bus between the RudolV pipeline (master) and the UART receiver (slave).
interface csr_uart_rx_if;
  logic        csr_read;
  logic [2:0]  csr_modify;
  logic [31:0] csr_wdata;
  logic [11:0] csr_addr;
  logic [31:0] csr_rdata;
  logic        csr_valid;

  modport master (
    output csr_read, csr_modify, csr_wdata, csr_addr,
    input  csr_rdata, csr_valid
  );

  modport slave (
    input  csr_read, csr_modify, csr_wdata, csr_addr,
    output csr_rdata, csr_valid
  );
endinterface

// File: rtl/csr_uart_rx_fifo.sv
// Synchronous byte FIFO; the head entry is visible combinationally on dout.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] PTR_ONE = {{DEPTH_LOG{1'b0}}, 1'b1};

  logic [7:0]         mem_q [DEPTH];
  logic [7:0]         mem_d [DEPTH];
  logic [DEPTH_LOG:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG:0] rd_ptr_q, rd_ptr_d;
  logic               do_pop_s;
  logic               do_push_s;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG] != rd_ptr_q[DEPTH_LOG]) &&
                 (wr_ptr_q[DEPTH_LOG-1:0] == rd_ptr_q[DEPTH_LOG-1:0]);
  assign dout  = mem_q[rd_ptr_q[DEPTH_LOG-1:0]];

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Next-state for storage and pointers.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q[DEPTH_LOG-1:0]] = din;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/csr_uart_rx.sv
// 8N1 UART receiver with a byte FIFO, read by the core through CSRs 0xbc0 (data) and 0xbc1 (divisor).
module csr_uart_rx
  import uart_pkg::*;
#(
  parameter logic [15:0] CLK_PER_BIT    = 16'd868,
  parameter int unsigned FIFO_DEPTH_LOG = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  csr_uart_rx_if.slave csr
);

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_q, div_d;
  logic [15:0] div_act_q, div_act_d;
  logic        ovr_q, ovr_d;
  logic        frm_q, frm_d;
  logic [11:0] addr_q;
  logic        read_q;
  logic [31:0] rdata_q, rdata_d;
  logic        valid_q, valid_d;

  logic        fall_s, expire_s, push_s, frm_set_s, ovr_set_s;
  logic        rd_uart_s, pop_s;
  logic        fifo_full_s, fifo_empty_s;
  logic [7:0]  fifo_dout_s;
  logic        wdata_unused_s;

  assign wdata_unused_s = ^csr.csr_wdata[31:16];

  assign fall_s   = rx_prev_q & ~rx_sync_q;
  assign expire_s = (cnt_q == 16'd0);

  // Only entries the core actually saw are popped, and only flags it saw are cleared.
  assign rd_uart_s = read_q & (addr_q == CSR_UART);
  assign pop_s     = rd_uart_s & rdata_q[VALID_BIT];
  assign ovr_set_s = push_s & fifo_full_s & ~pop_s;

  uart_rx_fifo #(
    .DEPTH_LOG(FIFO_DEPTH_LOG)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .pop  (pop_s),
    .din  (shift_q),
    .dout (fifo_dout_s),
    .full (fifo_full_s),
    .empty(fifo_empty_s)
  );

  // Receive FSM: mid-bit sampling driven by a down-counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    div_act_d = div_act_q;
    push_s    = 1'b0;
    frm_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall_s) begin
          state_d   = ST_START;
          div_act_d = div_q;
          cnt_d     = div_q >> 1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (!expire_s) begin
          cnt_d = cnt_q - 16'd1;
        end else if (rx_sync_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_DATA;
          cnt_d     = div_act_q - 16'd1;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (!expire_s) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          shift_d   = {rx_sync_q, shift_q[7:1]};
          cnt_d     = div_act_q - 16'd1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_STOP: begin
        if (!expire_s) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          state_d = ST_IDLE;
          if (rx_sync_q) begin
            push_s = 1'b1;
          end else begin
            frm_set_s = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CSR read data, flag update and divisor modify; a flag set beats a same-cycle clear.
  always_comb begin
    rdata_d = 32'd0;
    valid_d = 1'b0;
    if (csr.csr_addr == CSR_UART) begin
      valid_d = csr.csr_read | (csr.csr_modify != 3'd0);
      rdata_d = {21'd0, frm_q, ovr_q, ~fifo_empty_s, (fifo_empty_s ? 8'd0 : fifo_dout_s)};
    end else if (csr.csr_addr == CSR_UART_DIV) begin
      valid_d = csr.csr_read | (csr.csr_modify != 3'd0);
      rdata_d = {16'd0, div_q};
    end else begin
      valid_d = 1'b0;
    end
    if (!valid_d) begin
      rdata_d = 32'd0;
    end else begin
      rdata_d = rdata_d;
    end
    ovr_d = ovr_set_s | (ovr_q & ~(rd_uart_s & rdata_q[OVERRUN_BIT]));
    frm_d = frm_set_s | (frm_q & ~(rd_uart_s & rdata_q[FRAME_BIT]));
    if (addr_q == CSR_UART_DIV) begin
      div_d = div_update(csr.csr_modify, div_q, csr.csr_wdata[15:0]);
    end else begin
      div_d = div_q;
    end
  end

  // All block state, including the rx synchroniser and registered CSR outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      div_q     <= CLK_PER_BIT;
      div_act_q <= CLK_PER_BIT;
      ovr_q     <= 1'b0;
      frm_q     <= 1'b0;
      addr_q    <= 12'd0;
      read_q    <= 1'b0;
      rdata_q   <= 32'd0;
      valid_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      div_act_q <= div_act_d;
      ovr_q     <= ovr_d;
      frm_q     <= frm_d;
      addr_q    <= csr.csr_addr;
      read_q    <= csr.csr_read;
      rdata_q   <= rdata_d;
      valid_q   <= valid_d;
    end
  end

  assign csr.csr_rdata = rdata_q;
  assign csr.csr_valid = valid_q;

endmodule

// File: tb/tb_csr_uart_rx.sv
// Directed plus randomized bench for csr_uart_rx against a queue-based receiver model.
module tb_csr_uart_rx;

  logic clk = 1'b0;
  logic rst;
  logic rx;

  csr_uart_rx_if bus ();

  csr_uart_rx #(
    .CLK_PER_BIT   (16'd8),
    .FIFO_DEPTH_LOG(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx (rx),
    .csr(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: received bytes, sticky flags and current divisor.
  logic [7:0] exp_q[$];
  logic       m_ovr = 1'b0;
  logic       m_frm = 1'b0;
  int         div_m = 8;
  localparam int MODEL_DEPTH = 4;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read();
    logic [31:0] e;
    e = 32'd0;
    if (exp_q.size() > 0) begin
      e[7:0] = exp_q.pop_front();
      e[8]   = 1'b1;
    end
    e[9]  = m_ovr;
    e[10] = m_frm;
    m_ovr = 1'b0;
    m_frm = 1'b0;
    return e;
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    cyc(div_m);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(div_m);
    end
    rx = stop_ok;
    cyc(div_m);
    if (stop_ok) begin
      if (exp_q.size() < MODEL_DEPTH) exp_q.push_back(b);
      else m_ovr = 1'b1;
    end else begin
      m_frm = 1'b1;
    end
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d, output logic v);
    bus.csr_addr = a;
    bus.csr_read = 1'b1;
    cyc(1);
    bus.csr_read = 1'b0;
    bus.csr_addr = 12'h000;
    d = bus.csr_rdata;
    v = bus.csr_valid;
    cyc(1);
  endtask

  task automatic uart_read_check(input string tag);
    logic [31:0] d;
    logic        v;
    logic [31:0] e;
    csr_rd(12'hbc0, d, v);
    e = model_read();
    check(tag, d, e);
    check({tag, "_valid"}, {31'd0, v}, 32'd1);
  endtask

  task automatic div_write(input logic [2:0] op, input logic [31:0] w);
    int r;
    bus.csr_addr = 12'hbc1;
    cyc(1);
    bus.csr_addr   = 12'h000;
    bus.csr_modify = op;
    bus.csr_wdata  = w;
    cyc(1);
    bus.csr_modify = 3'd0;
    bus.csr_wdata  = 32'd0;
    case (op)
      3'd1:    r = int'(w[15:0]);
      3'd2:    r = div_m | int'(w[15:0]);
      3'd3:    r = div_m & ~int'(w[15:0]);
      default: r = div_m;
    endcase
    div_m = (r < 2) ? 2 : r;
  endtask

  task automatic div_read_check(input string tag);
    logic [31:0] d;
    logic        v;
    csr_rd(12'hbc1, d, v);
    check(tag, d, div_m);
    check({tag, "_valid"}, {31'd0, v}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic        v;
    int          k;
    logic [7:0]  b;
    logic        ok;

    rst = 1'b1;
    rx  = 1'b1;
    bus.csr_read   = 1'b0;
    bus.csr_modify = 3'd0;
    bus.csr_wdata  = 32'd0;
    bus.csr_addr   = 12'h000;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    check("reset_rdata", bus.csr_rdata, 32'd0);
    check("reset_valid", {31'd0, bus.csr_valid}, 32'd0);
    div_read_check("reset_div");

    // Single byte, then an empty read.
    send_frame(8'h55, 1'b1);
    cyc(100);
    uart_read_check("single_55");
    uart_read_check("single_empty");

    // Fill beyond depth: fifth byte overruns.
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    send_frame(8'h99, 1'b1);
    cyc(20);
    for (int i = 0; i < 5; i++) uart_read_check($sformatf("fifo_rd%0d", i));

    // Framing error then recovery.
    send_frame(8'hA5, 1'b0);
    cyc(20);
    uart_read_check("frame_err");
    rx = 1'b1;
    cyc(16);
    send_frame(8'h3C, 1'b1);
    cyc(20);
    uart_read_check("frame_recover");

    // Short low glitch is rejected.
    rx = 1'b0;
    cyc(2);
    rx = 1'b1;
    cyc(50);
    uart_read_check("glitch");

    // Divisor CSR.
    div_write(3'd1, 32'd20);
    div_read_check("div_20");
    send_frame(8'h7E, 1'b1);
    cyc(40);
    uart_read_check("div20_byte");
    div_write(3'd1, 32'd1);
    div_read_check("div_clamp");
    div_write(3'd2, 32'h0001_0010);
    div_read_check("div_set");
    div_write(3'd3, 32'h0000_0012);
    div_read_check("div_clear_clamp");
    div_write(3'd1, 32'd8);
    div_read_check("div_back_8");

    csr_rd(12'h123, d, v);
    check("other_valid", {31'd0, v}, 32'd0);
    check("other_rdata", d, 32'd0);

    // Randomized bursts with occasional bad stop bits.
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(1, 5);
      for (int j = 0; j < k; j++) begin
        b  = 8'($urandom);
        ok = ($urandom_range(0, 5) != 0);
        send_frame(b, ok);
        if (!ok) begin
          rx = 1'b1;
          cyc(2 * div_m);
        end
      end
      cyc(20);
      for (int j = 0; j <= k; j++) uart_read_check($sformatf("rand%0d_%0d", r, j));
    end

    // Reset mid-frame with a byte already buffered.
    send_frame(8'h5A, 1'b1);
    cyc(10);
    rx = 1'b0;
    cyc(3 * div_m);
    rst = 1'b1;
    rx  = 1'b1;
    cyc(1);
    rst = 1'b0;
    exp_q.delete();
    m_ovr = 1'b0;
    m_frm = 1'b0;
    div_m = 8;
    cyc(20);
    send_frame(8'hC3, 1'b1);
    cyc(20);
    uart_read_check("after_rst_c3");
    uart_read_check("after_rst_empty");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
